form_check_unit: RTL

- Parametrised successor to the single-bit form checker.
- Once the last CRC bit is seen, tracks the CAN frame tail: CRC delimiter, ACK slot, ACK delimiter and End-of-Frame (EOF). Each fixed-form bit is checked at the sample point.
- Reports form errors with the field and bit position, and flags overload conditions.
- Sits after the bit-destuffer/CRC checker and feeds the error-frame generator.

---
 rtl/form_check_unit_if.sv | 25 ++
 rtl/form_check_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/form_check_unit_if.sv
// Sample-point bus between the destuffer/CRC stage, the CAN frame-tail form checker
// and the error-frame generator. Signal names match the block's external port names.
interface form_check_unit_if;
    logic       SP;
    logic       RX;
    logic       CRC_DONE;
    logic       ABORT;
    logic       FORM_Error;
    logic [1:0] err_field;
    logic [3:0] err_bit;
    logic       ack_seen;
    logic       busy;
    logic       frame_ok;
    logic       overload_req;

    modport master (
        output SP, RX, CRC_DONE, ABORT,
        input  FORM_Error, err_field, err_bit, ack_seen, busy, frame_ok, overload_req
    );

    modport slave (
        input  SP, RX, CRC_DONE, ABORT,
        output FORM_Error, err_field, err_bit, ack_seen, busy, frame_ok, overload_req
    );
endinterface

// File: rtl/form_check_unit.sv
// CAN frame-tail form checker: CRC delimiter, ACK slot/delimiter and EOF checks.
// Optional intermission overload check enabled by defining FORM_IFS_CHECK_EN.
module form_check_unit #(
    parameter int unsigned EOF_LEN           = 7,
    parameter int unsigned LAST_EOF_TOLERANT = 1,
    parameter int unsigned IFS_LEN           = 3
) (
    input logic              clock,
    input logic              reset,
    form_check_unit_if.slave bus
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] EOF_LAST = CNT_W'(EOF_LEN - 1);

    if (EOF_LEN < 2 || EOF_LEN > 15 || IFS_LEN < 1 || IFS_LEN > 16) begin : g_bad_params
        $error("form_check_unit: EOF_LEN must be 2..15 and IFS_LEN 1..16");
    end

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        CRC_D        = 3'd1,
        ACK_SLOT     = 3'd2,
        ACK_D        = 3'd3,
        EOF          = 3'd4,
        INTERMISSION = 3'd5
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             form_error;
    logic [1:0]       err_field;
    logic [3:0]       err_bit;
    logic             ack_seen;
    logic             busy;
    logic             frame_ok;
    logic             overload_req;

`ifdef FORM_IFS_CHECK_EN
    localparam logic [CNT_W-1:0] IFS_LAST = CNT_W'(IFS_LEN - 1);
`endif

    // Tail sequencer; ABORT outranks everything, CRC_DONE restarts from any state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            count        <= '0;
            form_error   <= 1'b1;
            err_field    <= 2'd0;
            err_bit      <= 4'd0;
            ack_seen     <= 1'b0;
            busy         <= 1'b0;
            frame_ok     <= 1'b0;
            overload_req <= 1'b0;
        end else begin
            frame_ok     <= 1'b0;
            overload_req <= 1'b0;
            if (bus.ABORT) begin
                state <= IDLE;
                count <= '0;
                busy  <= 1'b0;
            end else if (bus.SP) begin
                if (bus.CRC_DONE) begin
                    state      <= CRC_D;
                    busy       <= 1'b1;
                    form_error <= 1'b1;
                    err_field  <= 2'd0;
                    err_bit    <= 4'd0;
                    ack_seen   <= 1'b0;
                end else begin
                    case (state)
                        CRC_D: begin
                            if (bus.RX) begin
                                state <= ACK_SLOT;
                            end else begin
                                form_error <= 1'b0;
                                err_field  <= 2'd1;
                                state      <= IDLE;
                                busy       <= 1'b0;
                            end
                        end
                        ACK_SLOT: begin
                            ack_seen <= ~bus.RX;
                            state    <= ACK_D;
                        end
                        ACK_D: begin
                            if (bus.RX) begin
                                state <= EOF;
                                count <= '0;
                            end else begin
                                form_error <= 1'b0;
                                err_field  <= 2'd2;
                                state      <= IDLE;
                                busy       <= 1'b0;
                            end
                        end
                        EOF: begin
                            if (bus.RX) begin
                                if (count == EOF_LAST) begin
                                    frame_ok <= 1'b1;
`ifdef FORM_IFS_CHECK_EN
                                    state    <= INTERMISSION;
                                    count    <= '0;
`else
                                    state    <= IDLE;
                                    busy     <= 1'b0;
`endif
                                end else begin
                                    count <= CNT_W'(count + CNT_W'(1));
                                end
                            end else begin
                                // A dominant last EOF bit may be an overload request, not an error.
                                if (count == EOF_LAST && LAST_EOF_TOLERANT != 0) begin
                                    overload_req <= 1'b1;
                                end else begin
                                    form_error <= 1'b0;
                                    err_field  <= 2'd3;
                                    err_bit    <= count;
                                end
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
`ifdef FORM_IFS_CHECK_EN
                        INTERMISSION: begin
                            if (!bus.RX) begin
                                // Dominant on the final intermission bit is a legal start of frame.
                                if (count < IFS_LAST) overload_req <= 1'b1;
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else if (count == IFS_LAST) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                count <= CNT_W'(count + CNT_W'(1));
                            end
                        end
`endif
                        default: begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.FORM_Error   = form_error;
    assign bus.err_field    = err_field;
    assign bus.err_bit      = err_bit;
    assign bus.ack_seen     = ack_seen;
    assign bus.busy         = busy;
    assign bus.frame_ok     = frame_ok;
    assign bus.overload_req = overload_req;
endmodule
